audio_stream_ctrl: RTL

Sequencer between the audio_codec read/write FIFO interface and a sample-processing datapath, such as a FIR filter. It pops one stereo sample from the codec and hands it to the processor over a valid/ready handshake. It then collects the result and pushes it back to the codec. It also provides bypass and mono modes, a processing timeout with a sticky error flag, and a processed-sample counter.

---
 rtl/audio_stream_ctrl_pkg.sv | 9 +
 rtl/audio_stream_ctrl_if.sv | 30 +++
 rtl/audio_stream_ctrl_timer.sv | 18 +
 rtl/audio_stream_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/audio_stream_ctrl_pkg.sv
// audio_pkg: shared sample width, FSM state encoding and stereo sample type
package audio_pkg;
    localparam int SAMPLE_W_DEF = 24;
    typedef enum logic [2:0] {IDLE, POP, PROC_REQ, PROC_WAIT, WR_WAIT, PUSH} state_e;
    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } stereo_t;
endpackage

// File: rtl/audio_stream_ctrl_if.sv
// audio_stream_ctrl_if: codec FIFO and processor handshake signals seen by the sequencer
interface audio_stream_ctrl_if import audio_pkg::*; #(parameter int SAMPLE_W = SAMPLE_W_DEF);
    logic                read_ready;
    logic [SAMPLE_W-1:0] readdata_left;
    logic [SAMPLE_W-1:0] readdata_right;
    logic                read;
    logic                write_ready;
    logic                write;
    logic [SAMPLE_W-1:0] writedata_left;
    logic [SAMPLE_W-1:0] writedata_right;
    logic                proc_valid;
    logic                proc_ready;
    logic [SAMPLE_W-1:0] proc_left;
    logic [SAMPLE_W-1:0] proc_right;
    logic                res_valid;
    logic [SAMPLE_W-1:0] res_left;
    logic [SAMPLE_W-1:0] res_right;
    modport master (
        input  read_ready, readdata_left, readdata_right, write_ready,
               proc_ready, res_valid, res_left, res_right,
        output read, write, writedata_left, writedata_right,
               proc_valid, proc_left, proc_right
    );
    modport slave (
        output read_ready, readdata_left, readdata_right, write_ready,
               proc_ready, res_valid, res_left, res_right,
        input  read, write, writedata_left, writedata_right,
               proc_valid, proc_left, proc_right
    );
endinterface

// File: rtl/audio_stream_ctrl_timer.sv
// proc_timer: clearable up-counter that saturates and flags expiry at TIMEOUT-1
module proc_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign expired_o = cnt_q == W'(TIMEOUT - 1);
    // count while enabled, stop at the expiry value, restart on clear
    always_comb cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + W'(1) : cnt_q;
    // counter register
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: pops codec samples, runs them through the processor (or bypass) and pushes results
module audio_stream_ctrl import audio_pkg::*; #(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    audio_stream_ctrl_if.master bus,
    input  logic                bypass,
    input  logic                mono,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    sample_count
);
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } smp_t;
    state_e             state_q, state_d;
    smp_t               smp_q, smp_d, wd_q, wd_d;
    logic               read_q, write_q, pv_q, err_q, err_d, expired;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    proc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (CLOCK_50),
        .rst       (reset),
        .clr_i     (state_q == PROC_REQ),
        .en_i      (state_q == PROC_WAIT),
        .expired_o (expired)
    );
    // next state, captured sample, result and bookkeeping
    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        wd_d    = wd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.read_ready) begin
                smp_d   = '{bus.readdata_left, mono ? bus.readdata_left : bus.readdata_right};
                state_d = POP;
            end
            POP: begin
                wd_d    = bypass ? smp_q : wd_q;
                state_d = bypass ? WR_WAIT : PROC_REQ;
            end
            PROC_REQ: state_d = bus.proc_ready ? PROC_WAIT : PROC_REQ;
            PROC_WAIT: if (bus.res_valid) begin
                wd_d    = '{bus.res_left, bus.res_right};
                state_d = WR_WAIT;
            end else if (expired) begin
                wd_d    = '0;
                err_d   = 1'b1;
                state_d = WR_WAIT;
            end
            WR_WAIT: state_d = bus.write_ready ? PUSH : WR_WAIT;
            PUSH: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, data and strobe registers; strobes decode the state being entered
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            smp_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            read_q  <= state_d == POP;
            write_q <= state_d == PUSH;
            pv_q    <= state_d == PROC_REQ;
        end
    end
    assign bus.read            = read_q;
    assign bus.write           = write_q;
    assign bus.proc_valid      = pv_q;
    assign bus.proc_left       = smp_q.left;
    assign bus.proc_right      = smp_q.right;
    assign bus.writedata_left  = wd_q.left;
    assign bus.writedata_right = wd_q.right;
    assign timeout_err         = err_q;
    assign sample_count        = cnt_q;
endmodule
